// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch port: a request/acknowledge bus between the
// fetch sequencer (master) and the instruction memory (slave).
interface pc_fetch_sequencer_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer.
// Issues one fetch at a time over the imem req/ack port, delivers fetched
// words to decode, resolves branches and flushes wrong-path fetches.
module pc_fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  branch_valid,
    input  logic                  bne_uc,
    input  logic                  beq_uc,
    input  logic                  jumpctrl_uc,
    input  logic                  zero_alu,
    input  logic [XLEN-1:0]       target_addr,
    pc_fetch_sequencer_if.master  imem,
    output logic [XLEN-1:0]       pc,
    output logic [XLEN-1:0]       instr_out,
    output logic                  instr_valid,
    output logic                  flush,
    output logic                  misalign_err,
    output logic [7:0]            redirect_cnt
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [XLEN-1:0] pc_nx;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] instr_nx;
    logic            valid_nx;
    logic            req_q;
    logic            req_nx;
    logic [XLEN-1:0] saved_tgt;
    logic [XLEN-1:0] saved_tgt_nx;
    logic            taken;
    logic            misaligned;
    logic            redirect;

    // Branch resolution: a taken branch only redirects when its target is word aligned.
    assign taken      = branch_valid & ((bne_uc & ~zero_alu) | (beq_uc & zero_alu) | jumpctrl_uc);
    assign misaligned = |target_addr[1:0];
    assign redirect   = taken & ~misaligned;
    assign pc_inc     = pc + STEP;

    // The fetch address is always the registered pc, so the bus is glitch-free.
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and next values of pc, delivered instruction and saved target.
    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        instr_nx     = instr_out;
        valid_nx     = instr_valid;
        saved_tgt_nx = saved_tgt;
        case (state)
            IDLE: begin
                valid_nx = 1'b0;
                state_nx = FETCH;
                if (redirect) begin
                    pc_nx = target_addr;
                end
            end
            FETCH: begin
                valid_nx = 1'b0;
                if (imem.imem_ack) begin
                    if (redirect) begin
                        // Wrong-path word arrives together with the branch: drop it.
                        pc_nx = target_addr;
                    end else begin
                        instr_nx = imem.imem_rdata;
                        valid_nx = 1'b1;
                        if (stall) begin
                            state_nx = HOLD;
                        end else begin
                            pc_nx = pc_inc;
                        end
                    end
                end else if (redirect) begin
                    // The request in flight cannot be abandoned; finish it and discard.
                    saved_tgt_nx = target_addr;
                    state_nx     = DRAIN;
                end
            end
            HOLD: begin
                if (redirect) begin
                    valid_nx = 1'b0;
                    pc_nx    = target_addr;
                    state_nx = FETCH;
                end else if (!stall) begin
                    valid_nx = 1'b0;
                    pc_nx    = pc_inc;
                    state_nx = FETCH;
                end
            end
            DRAIN: begin
                valid_nx = 1'b0;
                if (redirect) begin
                    saved_tgt_nx = target_addr;
                end
                if (imem.imem_ack) begin
                    pc_nx    = redirect ? target_addr : saved_tgt;
                    state_nx = FETCH;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        req_nx = (state_nx == FETCH) || (state_nx == DRAIN);
    end

    // Datapath registers: pc, delivered instruction, request line and saved redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            req_q       <= 1'b0;
            saved_tgt   <= '0;
        end else begin
            pc          <= pc_nx;
            instr_out   <= instr_nx;
            instr_valid <= valid_nx;
            req_q       <= req_nx;
            saved_tgt   <= saved_tgt_nx;
        end
    end

    // Branch status: flush pulse, sticky misalignment flag and saturating redirect count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush        <= 1'b0;
            misalign_err <= 1'b0;
            redirect_cnt <= 8'd0;
        end else begin
            flush <= redirect;
            if (taken && misaligned) begin
                misalign_err <= 1'b1;
            end
            if (redirect && (redirect_cnt != 8'hFF)) begin
                redirect_cnt <= redirect_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios followed by
// randomized fetch/branch/stall traffic against a transaction-level model.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic        bne_uc = 1'b0;
    logic        beq_uc = 1'b0;
    logic        jumpctrl_uc = 1'b0;
    logic        zero_alu = 1'b0;
    logic [31:0] target_addr = '0;
    logic [31:0] pc;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        flush;
    logic        misalign_err;
    logic [7:0]  redirect_cnt;

    pc_fetch_sequencer_if #(.XLEN(32)) imem_bus ();

    pc_fetch_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_valid (branch_valid),
        .bne_uc       (bne_uc),
        .beq_uc       (beq_uc),
        .jumpctrl_uc  (jumpctrl_uc),
        .zero_alu     (zero_alu),
        .target_addr  (target_addr),
        .imem         (imem_bus),
        .pc           (pc),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .flush        (flush),
        .misalign_err (misalign_err),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ack_log[$];

    int checks = 0;
    int failures = 0;

    bit          const_mem = 1'b0;
    bit          mon_en = 1'b0;
    bit          prev_req = 1'b0;

    // Reference model state: address the next acknowledged fetch must carry,
    // whether the fetch now in flight has been made wrong-path, and its replacement.
    logic [31:0] m_addr = '0;
    bit          m_discard = 1'b0;
    logic [31:0] m_pend = '0;
    int          n_cnt = 0;
    bit          n_err = 1'b0;
    bit          n_flush = 1'b0;
    int          e_cnt = 0;
    bit          e_err = 1'b0;
    bit          e_flush = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (const_mem) return 32'h0000_0013;
        return {addr[15:0], addr[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus. Called just after a rising edge; updates the model
    // with what must happen at the coming edge, then advances past that edge.
    task automatic step(input bit a, input bit st, input bit bv, input bit bn, input bit bq,
                        input bit jc, input bit z, input logic [31:0] tgt);
        bit tk;
        bit rd;
        stall        = st;
        branch_valid = bv;
        bne_uc       = bn;
        beq_uc       = bq;
        jumpctrl_uc  = jc;
        zero_alu     = z;
        target_addr  = tgt;
        imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
        imem_bus.imem_ack   = a & imem_bus.imem_req;

        tk = bv && ((bn && !z) || (bq && z) || jc);
        rd = tk && (tgt[1:0] == 2'b00);
        n_flush = rd;
        if (rd && n_cnt < 255) n_cnt++;
        if (tk && !rd) n_err = 1'b1;

        if (imem_bus.imem_ack) begin
            ack_log.push_back(imem_bus.imem_addr);
            chk("fetch_addr", imem_bus.imem_addr, m_addr);
            if (rd) begin
                m_addr = tgt;
            end else if (m_discard) begin
                m_addr = m_pend;
            end else begin
                exp_q.push_back('{instr: mem_word(m_addr), pc: st ? m_addr : m_addr + 32'd4});
                m_addr = m_addr + 32'd4;
            end
            m_discard = 1'b0;
        end else if (imem_bus.imem_req) begin
            if (rd) begin
                m_discard = 1'b1;
                m_pend    = tgt;
            end
        end else if (rd) begin
            m_addr = tgt;
        end

        @(posedge clk);
        #1;
        e_flush = n_flush;
        e_cnt   = n_cnt;
        e_err   = n_err;
        imem_bus.imem_ack = 1'b0;
        branch_valid = 1'b0;
    endtask

    // Asynchronous reset in the middle of whatever is in flight, with a stray ack held high.
    task automatic do_reset();
        rst_n = 1'b0;
        branch_valid = 1'b0;
        stall = 1'b0;
        imem_bus.imem_ack = 1'b1;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_err", {31'd0, misalign_err}, 32'd0);
        chk("rst_cnt", {24'd0, redirect_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        imem_bus.imem_ack = 1'b0;
        m_addr = 32'h0;
        m_discard = 1'b0;
        n_cnt = 0; n_err = 1'b0; n_flush = 1'b0;
        e_cnt = 0; e_err = 1'b0; e_flush = 1'b0;
        exp_q.delete();
        ack_log.delete();
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: status outputs every cycle, and each newly delivered instruction
    // against the head of the expected-delivery queue.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("flush", {31'd0, flush}, {31'd0, e_flush});
            chk("redirect_cnt", {24'd0, redirect_cnt}, e_cnt);
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, e_err});
            if (instr_valid && prev_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_delivery: got instr %h pc %h expected none", instr_out, pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("instr_out", instr_out, e.instr);
                    chk("deliver_pc", pc, e.pc);
                end
            end
            prev_req = imem_bus.imem_req;
        end else begin
            prev_req = 1'b0;
        end
    end

    initial begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = '0;
        #2;

        // Sequential fetch with constant NOP memory.
        const_mem = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("seq_addr0", ack_log[0], 32'h0);
        chk("seq_addr1", ack_log[1], 32'h4);
        chk("seq_addr2", ack_log[2], 32'h8);
        const_mem = 1'b0;

        // Taken bne while the fetch is outstanding, then ack: drained and redirected.
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 1, 1, 0, 0, 0, 32'h40);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("drain_target_addr", ack_log[ack_log.size()-1], 32'h40);
        chk("drain_cnt", {24'd0, redirect_cnt}, 32'd1);

        // Not-taken bne (zero set): sequential flow continues.
        step(1, 0, 1, 1, 0, 0, 1, 32'h80);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("nottaken_addr", ack_log[ack_log.size()-1], 32'h48);
        chk("nottaken_cnt", {24'd0, redirect_cnt}, 32'd1);

        // Stall at ack: instruction and pc held with the request dropped.
        step(1, 1, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 0, 0, 32'h0);
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_instr", instr_out, mem_word(32'h4C));
            chk("hold_req", {31'd0, imem_bus.imem_req}, 32'd0);
            chk("hold_pc", pc, 32'h4C);
        end
        step(0, 0, 0, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("after_hold_addr", ack_log[ack_log.size()-1], 32'h50);

        // Misaligned jump: sticky error, no redirect; reset clears it.
        step(0, 0, 1, 0, 0, 1, 0, 32'h42);
        chk("misalign_set", {31'd0, misalign_err}, 32'd1);
        chk("misalign_noflush", {31'd0, flush}, 32'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);
        chk("misalign_cnt", {24'd0, redirect_cnt}, 32'd1);
        do_reset();

        // PC wrap-around and counter saturation.
        step(0, 0, 0, 0, 0, 0, 0, 32'h0);
        step(1, 0, 1, 0, 0, 1, 0, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("wrap_top_addr", ack_log[ack_log.size()-2], 32'hFFFF_FFFC);
        chk("wrap_addr", ack_log[ack_log.size()-1], 32'h0);
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 0, 1, 0, 0, 1, 0, $urandom & 32'hFFFF_FFFC);
        end
        chk("cnt_saturated", {24'd0, redirect_cnt}, 32'd255);

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 9) < 3, 1'($urandom), 1'($urandom),
                     $urandom_range(0, 3) == 0, 1'($urandom), t);
            end
        end
        step(0, 0, 0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("pending_deliveries", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
